// File: rtl/multicycle_control.sv
// multicycle_control
// Finite-state control sequencer for the multi-cycle RV32I core. It walks each
// instruction through FETCH, DECODE, EXEC and optionally MEM and WB, waiting
// on the memory ready handshake, and counts retired instructions.
//
// Optional feature: define MULTICYCLE_CONTROL_TRAP_EN to make an illegal
// opcode lock the sequencer in TRAP with illegal_instr set. When it is left
// undefined, illegal opcodes execute as a NOP that retires.
//
// Parameters
//   ALUOP_W  width of alu_op (>= 3, upper bits always 0)
//   CNT_W    width of the instret counter
//
// Ports
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   opcode         instr[6:0] from the IR, sampled in DECODE
//   br_taken       branch condition from the ALU, sampled in EXEC
//   mem_ready      memory completes the current access this cycle
//   state          current state (FETCH=0 .. TRAP=5)
//   mem_req        memory request, held until mem_ready
//   mem_we         store qualifier for mem_req
//   ir_write       load IR from memory read data
//   pc_write       update the PC
//   pc_sel         0 = PC+4, 1 = branch/jump target
//   alu_src        ALU operand B is the immediate
//   alu_op         ALU operation class
//   mem_to_reg     writeback data comes from memory
//   reg_write      register-file write enable
//   illegal_instr  sticky illegal-opcode flag
//   instret        retired-instruction count
module multicycle_control #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               br_taken,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_sel,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_instr,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_LUI     = 3'd1,
        C_JAL     = 3'd2,
        C_BRANCH  = 3'd3,
        C_LOAD    = 3'd4,
        C_STORE   = 3'd5,
        C_OPIMM   = 3'd6,
        C_OP      = 3'd7
    } class_t;

    state_t cur_state;
    state_t next_state;
    class_t instr_class;
    class_t decoded_class;
    logic   retire;

    assign state = cur_state;

    // Opcode to instruction class; only consulted while in DECODE.
    always_comb begin
        decoded_class = C_ILLEGAL;
        case (opcode)
            7'b0110111: decoded_class = C_LUI;
            7'b1101111: decoded_class = C_JAL;
            7'b1100011: decoded_class = C_BRANCH;
            7'b0000011: decoded_class = C_LOAD;
            7'b0100011: decoded_class = C_STORE;
            7'b0010011: decoded_class = C_OPIMM;
            7'b0110011: decoded_class = C_OP;
            default:    decoded_class = C_ILLEGAL;
        endcase
    end

    // State, latched class and retire counter. The class is captured on the
    // edge leaving DECODE so the IR may change underneath later states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_FETCH;
            instr_class <= C_ILLEGAL;
            instret     <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE) begin
                instr_class <= decoded_class;
            end
            if (retire) begin
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next state and control outputs. Everything is qualified by rst_n so
    // the enables drop the instant reset asserts, even mid-access, and the
    // first fetch request appears as soon as reset is released.
    always_comb begin
        next_state    = cur_state;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 1'b0;
        alu_src       = 1'b0;
        alu_op        = '0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        if (rst_n) begin
            case (cur_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                    next_state = (decoded_class == C_ILLEGAL) ? S_TRAP : S_EXEC;
`else
                    next_state = S_EXEC;
`endif
                end
                S_EXEC: begin
                    case (instr_class)
                        C_LUI: begin
                            alu_src    = 1'b1;
                            alu_op[2:0] = 3'b000;
                            next_state = S_WB;
                        end
                        C_OPIMM: begin
                            alu_src    = 1'b1;
                            alu_op[2:0] = 3'b100;
                            next_state = S_WB;
                        end
                        C_OP: begin
                            alu_op[2:0] = 3'b101;
                            next_state = S_WB;
                        end
                        C_LOAD: begin
                            alu_src    = 1'b1;
                            alu_op[2:0] = 3'b010;
                            next_state = S_MEM;
                        end
                        C_STORE: begin
                            alu_src    = 1'b1;
                            alu_op[2:0] = 3'b011;
                            next_state = S_MEM;
                        end
                        C_BRANCH: begin
                            alu_op[2:0] = 3'b001;
                            pc_write   = br_taken;
                            pc_sel     = 1'b1;
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end
                        C_JAL: begin
                            alu_src    = 1'b1;
                            pc_write   = 1'b1;
                            pc_sel     = 1'b1;
                            reg_write  = 1'b1;
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end
                        default: begin
                            // Illegal opcode executed as a NOP.
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (instr_class == C_STORE);
                    if (mem_ready) begin
                        if (instr_class == C_STORE) begin
                            retire     = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            next_state = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (instr_class == C_LOAD);
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
                S_TRAP: begin
                    illegal_instr = 1'b1;
                    next_state    = S_TRAP;
                end
`endif
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I core. It replaces the single-cycle opcode decoder with a finite-state sequencer that supports a memory ready handshake, the R-type ALU class, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register and the datapath, and drives the PC, IR, ALU, register file and memory-port enables.

## Interface
- ALUOP_W, 3: width of alu_op. Must be ≥3; upper bits are driven 0.
- CNT_W, 32: width of the instret counter.

- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0] from the IR; sampled only in DECODE
- br_taken  in  1  branch-condition result from the ALU; sampled only in EXEC
- mem_ready  in  1  memory port completes the current mem_req access this cycle
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  store qualifier for mem_req
- ir_write  out  1  load the IR from memory read data
- pc_write  out  1  update the PC
- pc_sel  out  1  0 = PC+4, 1 = branch/jump target
- alu_src  out  1  ALU operand B is the immediate
- alu_op  out  ALUOP_W  ALU operation class
- mem_to_reg  out  1  writeback data comes from memory
- reg_write  out  1  register-file write enable
- illegal_instr  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

## Operation
- The opcode is decoded in DECODE into a class register (LUI, JAL, BRANCH, LOAD, STORE, OPIMM, OP, ILLEGAL). Later states use only this register, so the opcode input may change after DECODE.
- Opcode map:
  - 0110111 LUI
  - 1101111 JAL
  - 1100011 BRANCH
  - 0000011 LOAD
  - 0100011 STORE
  - 0010011 OPIMM
  - 0110011 OP
  - any other value → ILLEGAL
- alu_op by class: LUI/JAL 000, BRANCH 001, LOAD 010, STORE 011, OPIMM 100, OP 101.
- alu_src = 1 for every class except BRANCH and OP.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_sel=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: latch the class, then go to EXEC. ILLEGAL goes to TRAP instead (see Configuration).
- EXEC: drive alu_op and alu_src, then branch by class:
  - LUI, OPIMM, OP → WB.
  - LOAD, STORE → MEM.
  - BRANCH: pc_write=br_taken, pc_sel=1; retire; → FETCH.
  - JAL: pc_write=1, pc_sel=1, reg_write=1, mem_to_reg=0; retire; → FETCH.
- MEM:
  - mem_req=1; mem_we=1 for STORE, 0 for LOAD.
  - Stay in MEM until mem_ready.
  - On mem_ready: LOAD → WB; STORE retires and → FETCH.
- WB: reg_write=1, mem_to_reg=1 for LOAD and 0 otherwise; retire; → FETCH.
- Retire: instret increments by 1 on the clock edge that leaves the retiring state. It wraps from 2^CNT_W−1 to 0.
- mem_ready is ignored in DECODE, EXEC, WB and TRAP.
- Control outputs are 0 in any state or class where they are not listed as asserted.

## Timing
- Reset (asynchronous, any state, including mid-access): state=FETCH, all control outputs 0, illegal_instr=0, instret=0, class register cleared. The first mem_req is asserted in the first cycle after rst_n deasserts.
- ir_write, pc_write in FETCH and the MEM exit are combinational on mem_ready (Mealy). All other outputs are decoded from state plus class only (Moore).
- Cycles per instruction with zero wait states (mem_ready=1 in the first request cycle):
  - BRANCH, JAL: 3
  - OPIMM, OP, LUI, STORE: 4
  - LOAD: 5
- Each wait cycle in FETCH or MEM adds exactly 1 cycle.
- mem_req is never dropped before mem_ready while in FETCH or MEM.

## Configuration
- MULTICYCLE_CONTROL_TRAP_EN defined:
  - ILLEGAL goes DECODE → TRAP.
  - TRAP holds illegal_instr=1 and all other control outputs 0 until reset; no retire occurs.
- MULTICYCLE_CONTROL_TRAP_EN undefined:
  - ILLEGAL is executed as a NOP: DECODE → EXEC → FETCH with no enables asserted.
  - The NOP retires.
  - illegal_instr is tied to 0 and TRAP is unreachable.

## Test plan
- Reset mid-MEM of a LOAD with mem_req high → state=0, mem_req=0, instret=0 immediately, before the next clock edge.
- OPIMM (0010011) with mem_ready always 1 → states 0,1,2,4,0; reg_write=1 only in WB; alu_op=100; instret increments by 1 after 4 cycles.
- LOAD with mem_ready held low for 2 cycles in MEM → MEM lasts 3 cycles with mem_req=1, mem_we=0; then WB with mem_to_reg=1; total 7 cycles.
- BRANCH with br_taken=0 then br_taken=1 → pc_write=0 and then 1 in EXEC, pc_sel=1 both times; 3 cycles each.
- Opcode 1111111 → with the macro: state=5, illegal_instr=1, instret frozen for 10 cycles. Without the macro: retires in 3 cycles with no enables.
- instret preloaded to all-ones (CNT_W=4, after 15 retires) → next retire gives instret=0.
